// File: rtl/jaa_pkg.sv
// Shared constants for the ARM-to-Java-bytecode peephole decoder:
// Java opcodes, ARM word patterns, FSM states and the emission bundle.
package jaa_pkg;

    localparam logic [7:0] JBC_ICONST_0 = 8'h03;
    localparam logic [7:0] JBC_ILOAD    = 8'h15;
    localparam logic [7:0] JBC_ILOAD_0  = 8'h1A;
    localparam logic [7:0] JBC_ISTORE   = 8'h36;
    localparam logic [7:0] JBC_ISTORE_0 = 8'h3B;
    localparam logic [7:0] JBC_DUP      = 8'h59;
    localparam logic [7:0] JBC_DUP_X1   = 8'h5A;
    localparam logic [7:0] JBC_SWAP     = 8'h5F;
    localparam logic [7:0] JBC_IADD     = 8'h60;

    localparam logic [31:0] ARM_MOV1     = 32'hE3A01000;
    localparam logic [31:0] ARM_ADD      = 32'hE0810002;
    localparam logic [23:0] ARM_LDR_PFX  = 24'hE59130;
    localparam logic [23:0] ARM_STR_PFX  = 24'hE58130;
    localparam logic [15:0] ARM_PUSH_PFX = 16'hE92D;
    localparam logic [15:0] ARM_POP_PFX  = 16'hE8BD;

    localparam logic [15:0] RL_R0  = 16'h0001;
    localparam logic [15:0] RL_R1  = 16'h0002;
    localparam logic [15:0] RL_R01 = 16'h0003;
    localparam logic [15:0] RL_R12 = 16'h0006;

    localparam logic [2:0] MOV_K_MAX = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOV_K,
        ST_LDR_N,
        ST_POP0,
        ST_POP0_PUSH0,
        ST_POP01,
        ST_POP01_PUSH1,
        ST_POP12
    } state_e;

    typedef struct packed {
        logic       emit;
        logic       two;
        logic [7:0] b0;
        logic [7:0] b1;
    } emit_t;

    // Local slots 0..3 have a one-byte form; others take opcode + index.
    function automatic emit_t short_form(input logic [7:0] short_op,
                                         input logic [7:0] long_op,
                                         input logic [7:0] n);
        emit_t e;
        e.emit = 1'b1;
        if (n <= 8'd3) begin
            e.two = 1'b0;
            e.b0  = short_op + n;
            e.b1  = 8'h00;
        end else begin
            e.two = 1'b1;
            e.b0  = long_op;
            e.b1  = n;
        end
        return e;
    endfunction

endpackage

// File: rtl/arm2jbc_out_buf.sv
// Two-entry byte FIFO; a write may carry one or two bytes at once,
// the read side is a valid/ready stream with the oldest byte first.
module arm2jbc_out_buf (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_two,
    input  logic [7:0] wr_b0,
    input  logic [7:0] wr_b1,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_byte,
    output logic       empty
);

    logic [7:0] b0_q, b0_d;
    logic [7:0] b1_q, b1_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pop;

    assign rd_valid = (cnt_q != 2'd0);
    assign rd_byte  = rd_valid ? b0_q : 8'h00;
    assign empty    = (cnt_q == 2'd0);
    assign pop      = rd_valid && rd_ready;

    always_comb begin
        b0_d  = b0_q;
        b1_d  = b1_q;
        cnt_d = cnt_q;
        if (pop) begin
            b0_d  = b1_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (wr_en) begin
            if (cnt_d == 2'd0) begin
                b0_d  = wr_b0;
                b1_d  = wr_b1;
                cnt_d = wr_two ? 2'd2 : 2'd1;
            end else if (cnt_d == 2'd1 && !wr_two) begin
                b1_d  = wr_b0;
                cnt_d = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b0_q  <= 8'h00;
            b1_q  <= 8'h00;
            cnt_q <= 2'd0;
        end else begin
            b0_q  <= b0_d;
            b1_q  <= b1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/arm2jbc_decoder.sv
// Folds ARM stack-machine idioms back into Java bytecodes.
// Define ARM2JBC_STATS_EN to add the instr_count / err_count ports.
module arm2jbc_decoder
    import jaa_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
`ifdef ARM2JBC_STATS_EN
    ,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] err_count
`endif
);

    state_e     state_q, state_d;
    logic [7:0] arg_q, arg_d;
    logic       err_q, err_d;
    emit_t      em;
    logic       accept;
    logic       buf_empty;

    logic w_mov, w_ldr, w_str, w_add;
    logic w_push0, w_push1, w_push01;
    logic w_pop0, w_pop01, w_pop12;

    assign accept = in_valid && in_ready;

    assign w_mov    = (in_word[31:3] == ARM_MOV1[31:3]) &&
                      (in_word[2:0] <= MOV_K_MAX);
    assign w_ldr    = (in_word[31:8] == ARM_LDR_PFX);
    assign w_str    = (in_word[31:8] == ARM_STR_PFX);
    assign w_add    = (in_word == ARM_ADD);
    assign w_push0  = (in_word == {ARM_PUSH_PFX, RL_R0});
    assign w_push1  = (in_word == {ARM_PUSH_PFX, RL_R1});
    assign w_push01 = (in_word == {ARM_PUSH_PFX, RL_R01});
    assign w_pop0   = (in_word == {ARM_POP_PFX, RL_R0});
    assign w_pop01  = (in_word == {ARM_POP_PFX, RL_R01});
    assign w_pop12  = (in_word == {ARM_POP_PFX, RL_R12});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            arg_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            err_q   <= err_d;
        end
    end

    // Every accepted word either advances a sequence or lands in IDLE.
    always_comb begin
        state_d = state_q;
        arg_d   = arg_q;
        if (accept) begin
            state_d = ST_IDLE;
            case (state_q)
                ST_IDLE: begin
                    if (w_mov) begin
                        state_d = ST_MOV_K;
                        arg_d   = {5'd0, in_word[2:0]};
                    end else if (w_ldr) begin
                        state_d = ST_LDR_N;
                        arg_d   = in_word[7:0];
                    end else if (w_pop0) begin
                        state_d = ST_POP0;
                    end else if (w_pop01) begin
                        state_d = ST_POP01;
                    end else if (w_pop12) begin
                        state_d = ST_POP12;
                    end
                end
                ST_POP0:  if (w_push0) state_d = ST_POP0_PUSH0;
                ST_POP01: if (w_push1) state_d = ST_POP01_PUSH1;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        em    = '0;
        err_d = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    err_d = !(w_mov || w_ldr || w_pop0 ||
                              w_pop01 || w_pop12);
                end
                ST_MOV_K: begin
                    if (w_push1) begin
                        em.emit = 1'b1;
                        em.b0   = JBC_ICONST_0 + arg_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_LDR_N: begin
                    if (w_push1) em = short_form(JBC_ILOAD_0, JBC_ILOAD, arg_q);
                    else         err_d = 1'b1;
                end
                ST_POP0: begin
                    if (w_str)
                        em = short_form(JBC_ISTORE_0, JBC_ISTORE, in_word[7:0]);
                    else if (!w_push0)
                        err_d = 1'b1;
                end
                ST_POP0_PUSH0: begin
                    if (w_push1) begin
                        em.emit = 1'b1;
                        em.b0   = JBC_DUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_POP01: begin
                    if (w_push01) begin
                        em.emit = 1'b1;
                        em.b0   = JBC_SWAP;
                    end else if (!w_push1) begin
                        err_d = 1'b1;
                    end
                end
                ST_POP01_PUSH1: begin
                    if (w_push01) begin
                        em.emit = 1'b1;
                        em.b0   = JBC_DUP_X1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_POP12: begin
                    if (w_add) begin
                        em.emit = 1'b1;
                        em.b0   = JBC_IADD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    assign err      = err_q;
    assign in_ready = buf_empty;

    arm2jbc_out_buf u_out_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (em.emit),
        .wr_two   (em.two),
        .wr_b0    (em.b0),
        .wr_b1    (em.b1),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_byte  (out_byte),
        .empty    (buf_empty)
    );

`ifdef ARM2JBC_STATS_EN
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (em.emit && !(&instr_cnt_q)) instr_cnt_d = instr_cnt_q + 1'b1;
        if (err_d && !(&err_cnt_q))     err_cnt_d   = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign instr_count = instr_cnt_q;
    assign err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_arm2jbc_decoder.sv
// Directed and random stimulus for arm2jbc_decoder with a byte
// scoreboard; expected bytes are queued as each sequence is driven.
module tb_arm2jbc_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        err;
`ifdef ARM2JBC_STATS_EN
    logic [15:0] instr_count;
    logic [15:0] err_count;
`endif

    arm2jbc_decoder #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_word     (in_word),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err         (err)
`ifdef ARM2JBC_STATS_EN
        ,
        .instr_count (instr_count),
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] exp_q[$];
    int         err_seen = 0;
    int         exp_err_total = 0;
    int         exp_instr = 0;
    int         exp_errc = 0;
    bit         rand_rdy = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] w);
        bit done = 1'b0;
        in_word  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic send_bad(input logic [31:0] w);
        send(w);
        check("err_pulse", 32'(err), 32'd1);
        exp_err_total++;
        exp_errc++;
        tick();
        check("err_clear", 32'(err), 32'd0);
    endtask

    task automatic exp_ins(input logic [7:0] b0, input bit two,
                           input logic [7:0] b1);
        exp_q.push_back(b0);
        if (two) exp_q.push_back(b1);
        exp_instr++;
    endtask

    task automatic exp_slot(input logic [7:0] sop, input logic [7:0] lop,
                            input logic [7:0] n);
        if (n < 8'd4) exp_ins(sop + n, 1'b0, 8'h00);
        else          exp_ins(lop, 1'b1, n);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
            else tick();
        end
        check("drain", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_instr = 0;
        exp_errc  = 0;
    endtask

    task automatic check_idle_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ARM2JBC_STATS_EN
        check("rst_instr_count", 32'(instr_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
`endif
    endtask

    task automatic check_stats();
        check("err_seen", 32'(err_seen), 32'(exp_err_total));
`ifdef ARM2JBC_STATS_EN
        check("instr_count", 32'(instr_count), 32'(exp_instr));
        check("err_count", 32'(err_count), 32'(exp_errc));
`endif
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_byte", 32'(out_byte), 32'(prev_byte));
            end
            if (err) err_seen++;
            if (out_valid && out_ready) begin
                check("sb_underflow", 32'(exp_q.size() == 0), 32'd0);
                if (exp_q.size() != 0)
                    check("out_byte", 32'(out_byte), 32'(exp_q.pop_front()));
            end
            stall_prev = out_valid && !out_ready;
            prev_byte  = out_byte;
        end
    end

    initial begin
        logic [7:0] n;
        in_valid  = 1'b0;
        in_word   = 32'h0;
        out_ready = 1'b1;
        do_reset();
        check_idle_reset();

        // mov r1,#4; push {r1}
        exp_ins(8'h07, 1'b0, 8'h00);
        send(32'hE3A01004);
        send(32'hE92D0002);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_byte", 32'(out_byte), 32'h07);
        check("no_err", 32'(err), 32'd0);
        drain();

        // wide iload with a stalled sink
        out_ready = 1'b0;
        exp_ins(8'h15, 1'b1, 8'h07);
        send(32'hE5913007);
        send(32'hE92D0002);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_byte", 32'(out_byte), 32'h15);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check("stall_byte_end", 32'(out_byte), 32'h15);
        out_ready = 1'b1;
        drain();
        check("drained_in_ready", 32'(in_ready), 32'd1);

        exp_ins(8'h59, 1'b0, 8'h00);
        send(32'hE8BD0001); send(32'hE92D0001); send(32'hE92D0002);
        exp_ins(8'h5A, 1'b0, 8'h00);
        send(32'hE8BD0003); send(32'hE92D0002); send(32'hE92D0003);
        exp_ins(8'h5F, 1'b0, 8'h00);
        send(32'hE8BD0003); send(32'hE92D0003);
        drain();

        do_reset();
        send(32'hE8BD0006);
        send_bad(32'hE3A01000);
        exp_ins(8'h03, 1'b0, 8'h00);
        send(32'hE3A01000); send(32'hE92D0002);
        drain();
        check_stats();

        // illegal first words and operand boundaries
        send_bad(32'hE92D0002);
        send_bad(32'hE3A01006);
        send_bad(32'hE5913100);
        exp_ins(8'h1D, 1'b0, 8'h00);
        send(32'hE5913003); send(32'hE92D0002);
        exp_ins(8'h15, 1'b1, 8'h04);
        send(32'hE5913004); send(32'hE92D0002);
        exp_ins(8'h36, 1'b1, 8'hFF);
        send(32'hE8BD0001); send(32'hE58130FF);
        exp_ins(8'h08, 1'b0, 8'h00);
        send(32'hE3A01005); send(32'hE92D0002);
        drain();
        check_stats();

        // reset mid-sequence, then with buffered bytes
        send(32'hE8BD0001);
        do_reset();
        check("midseq_err", 32'(err), 32'd0);
        send_bad(32'hE5813002);
        check("no_output", 32'(out_valid), 32'd0);
        exp_ins(8'h3D, 1'b0, 8'h00);
        send(32'hE8BD0001); send(32'hE5813002);
        drain();
        out_ready = 1'b0;
        send(32'hE5913009); send(32'hE92D0002);
        do_reset();
        check_idle_reset();
        out_ready = 1'b1;

        exp_ins(8'h60, 1'b0, 8'h00);
        send(32'hE8BD0006); send(32'hE0810002);
        drain();
        check_stats();

        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            n = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 6))
                0: begin
                    n = 8'($urandom_range(0, 5));
                    exp_ins(8'h03 + n, 1'b0, 8'h00);
                    send(32'hE3A01000 | 32'(n)); send(32'hE92D0002);
                end
                1: begin
                    exp_slot(8'h1A, 8'h15, n);
                    send(32'hE5913000 | 32'(n)); send(32'hE92D0002);
                end
                2: begin
                    exp_slot(8'h3B, 8'h36, n);
                    send(32'hE8BD0001); send(32'hE5813000 | 32'(n));
                end
                3: begin
                    exp_ins(8'h59, 1'b0, 8'h00);
                    send(32'hE8BD0001); send(32'hE92D0001);
                    send(32'hE92D0002);
                end
                4: begin
                    exp_ins(8'h5A, 1'b0, 8'h00);
                    send(32'hE8BD0003); send(32'hE92D0002);
                    send(32'hE92D0003);
                end
                5: begin
                    exp_ins(8'h5F, 1'b0, 8'h00);
                    send(32'hE8BD0003); send(32'hE92D0003);
                end
                default: begin
                    exp_ins(8'h60, 1'b0, 8'h00);
                    send(32'hE8BD0006); send(32'hE0810002);
                end
            endcase
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        drain();
        tick();
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/arm2jbc_decoder.md
ARM2JBC_DECODER -- requirements
Module: arm2jbc_decoder

Interface
- REQ-001: Parameter CNT_W, default 16, width of the statistics counters.
- REQ-002: clk  input  1  clock; all logic on the rising edge.
- REQ-003: reset  input  1  synchronous, active-high.
- REQ-004: in_word  input  32  ARM instruction word.
- REQ-005: in_valid  input  1  in_word valid.
- REQ-006: in_ready  output  1  decoder accepts in_word this cycle.
- REQ-007: out_byte  output  8  Java bytecode byte.
- REQ-008: out_valid  output  1  out_byte valid.
- REQ-009: out_ready  input  1  sink accepts out_byte.
- REQ-010: err  output  1  one-cycle pulse on an unrecognised sequence.
- REQ-011: instr_count  output  CNT_W  count of decoded bytecode instructions (ARM2JBC_STATS_EN only).
- REQ-012: err_count  output  CNT_W  count of err pulses (ARM2JBC_STATS_EN only).

Function
- REQ-013: A word SHALL be accepted on a cycle with in_valid and in_ready both high; out_byte SHALL be consumed on a cycle with out_valid and out_ready both high.
- REQ-014: Recognised words: MOV1 = E3A01000|k (k 0..5); LDR = E5913000|n; STR = E5813000|n (n 0..255, imm12[11:8] zero); PUSH/POP = E92D/E8BD prefix plus 16-bit register list; ADD = E0810002.
- REQ-015: Sequences to emit:
  - MOV1(k), PUSH{r1} -> 03+k.
  - LDR(n), PUSH{r1} -> 1A+n for n<=3, else 15,n.
  - POP{r0}, STR(n) -> 3B+n for n<=3, else 36,n.
  - POP{r1,r2}, ADD -> 60.
  - POP{r0}, PUSH{r0}, PUSH{r1} -> 59 (dup).
  - POP{r0,r1}, PUSH{r0,r1} -> 5F (swap).
  - POP{r0,r1}, PUSH{r1}, PUSH{r0,r1} -> 5A (dup_x1).
- REQ-016: FSM states: IDLE, MOV_K, LDR_N, POP0, POP0_PUSH0, POP01, POP01_PUSH1, POP12; a k or n value SHALL be latched in MOV_K or LDR_N.
- REQ-017: Transitions SHALL follow REQ-015 word by word; POP01 followed by PUSH{r0,r1} SHALL emit 5F, and POP01 followed by PUSH{r1} SHALL go to POP01_PUSH1.
- REQ-018: Any word that does not continue the current sequence, including a first word not in REQ-015, SHALL discard the partial sequence and the word, pulse err on the next cycle, and return to IDLE.
- REQ-019: The emitted bytes of an instruction SHALL be written to a 2-entry output buffer, with out_valid high on the cycle after the final word is accepted (latency 1).
- REQ-020: in_ready SHALL be high only while the output buffer is empty, so a 2-byte emission never stalls mid-instruction.
- REQ-021: A two-byte instruction SHALL present the opcode first, then the operand, and out_byte SHALL hold stable while out_valid is high and out_ready is low.
- REQ-022: instr_count SHALL increment once per emitted instruction and err_count once per err pulse, both saturating at all-ones.

Reset
- REQ-023: On reset the FSM SHALL return to IDLE, the buffer SHALL empty, out_valid, err and out_byte SHALL be 0, both counters SHALL be 0, and in_ready SHALL be 1 on the first cycle after reset.
- REQ-024: A reset mid-sequence or with buffered bytes SHALL drop them without an err pulse.

Configuration
- REQ-025: With ARM2JBC_STATS_EN defined, instr_count and err_count SHALL exist as in REQ-022; without it, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
- REQ-026: Package jaa_pkg SHALL hold the Java opcode constants, ARM prefix/word constants, and the FSM state enum.
- REQ-027: The output buffer SHALL be sub-module arm2jbc_out_buf, a 2-entry byte FIFO with a valid/ready read side.

Verification
- REQ-028: E3A01004, E92D0002 -> out 07, no err.
- REQ-029: E5913007, E92D0002 -> out 15 then 07 with out_ready held low 3 cycles; bytes remain stable and in_ready stays low until drained.
- REQ-030: E8BD0001, E92D0001, E92D0002 -> 59; E8BD0003, E92D0002, E92D0003 -> 5A; E8BD0003, E92D0003 -> 5F.
- REQ-031: E8BD0006, E3A01000 -> err pulse; then E3A01000, E92D0002 -> 03; err_count=1, instr_count=1 with STATS_EN.
- REQ-032: E8BD0001, then reset, then E5813002 -> err pulse with no output; then E8BD0001, E5813002 -> 3D.
- REQ-033: E8BD0006, E0810002 -> 60; random legal sequences with random out_ready SHALL match a reference-model byte stream.
